mem_scanner: RTL and testbench

//   Read-side companion to the 8x8 button-written memory.

---
 rtl/mem_scanner_pkg.sv | 19 +
 rtl/mem_scanner_if.sv | 34 +++
 rtl/hex2seven_seg.sv | 40 ++++
 rtl/mem_scanner_button_edge.sv | 38 +++
 rtl/mem_scanner.sv | 208 ++++++++++++++++++++
 tb/tb_mem_scanner.sv | 310 +++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mem_scanner_pkg.sv
// mem_scanner_pkg
//   Shared definitions for the memory scanner: FSM state encoding and
//   parameter defaults.
//   No ports.
package mem_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam int ADDR_W_DEF  = 3;
  localparam int DATA_W_DEF  = 8;
  localparam int DWELL_DEF   = 50_000_000;
  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/mem_scanner_if.sv
// mem_scanner_if
//   Read bus between the scanner (master) and the memory (slave).
//   Signals:
//     rd_addr   master->slave  address being read
//     rd_req    master->slave  one-cycle read request
//     rd_data   slave->master  read data, valid only with rd_valid
//     rd_valid  slave->master  read data strobe
interface mem_scanner_if
  import mem_scanner_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [ADDR_W-1:0] rd_addr;
  logic              rd_req;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport master (
    output rd_addr,
    output rd_req,
    input  rd_data,
    input  rd_valid
  );

  modport slave (
    input  rd_addr,
    input  rd_req,
    output rd_data,
    output rd_valid
  );

endinterface

// File: rtl/hex2seven_seg.sv
// hex2seven_seg
//   Hex nibble to seven-segment decoder, segments active-high as {g,f,e,d,c,b,a}.
//   Ports:
//     i_ce   in   1  enable; segments blank when 0
//     i_hex  in   4  nibble to show
//     o_seg  out  7  segment drive
module hex2seven_seg (
  input  logic       i_ce,
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  logic [6:0] w_seg;

  always_comb begin
    w_seg = 7'h00;
    case (i_hex)
      4'h0: w_seg = 7'h3F;
      4'h1: w_seg = 7'h06;
      4'h2: w_seg = 7'h5B;
      4'h3: w_seg = 7'h4F;
      4'h4: w_seg = 7'h66;
      4'h5: w_seg = 7'h6D;
      4'h6: w_seg = 7'h7D;
      4'h7: w_seg = 7'h07;
      4'h8: w_seg = 7'h7F;
      4'h9: w_seg = 7'h6F;
      4'hA: w_seg = 7'h77;
      4'hB: w_seg = 7'h7C;
      4'hC: w_seg = 7'h39;
      4'hD: w_seg = 7'h5E;
      4'hE: w_seg = 7'h79;
      4'hF: w_seg = 7'h71;
      default: w_seg = 7'h00;
    endcase
  end

  assign o_seg = i_ce ? w_seg : 7'h00;

endmodule

// File: rtl/mem_scanner_button_edge.sv
// button_edge
//   Raw active-low button -> synchronised press pulse. The pin is inverted,
//   passed through two flops, and the 0->1 edge of the synchronised level
//   becomes a registered one-cycle pulse, three clocks after the pin falls.
//   Ports:
//     i_clk    in   1  clock
//     i_rst_n  in   1  asynchronous active-low reset
//     i_btn_n  in   1  raw button, active-low, asynchronous to i_clk
//     o_pulse  out  1  one-cycle press pulse
module button_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_n,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_pulse;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= ~i_btn_n;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_pulse <= r_sync2 & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/mem_scanner.sv
// mem_scanner
//   Walks memory addresses in order, issues one read per address, and shows
//   the returned byte on LEDs and three seven-segment digits. Run mode
//   auto-advances every DWELL(+overhead) clocks; otherwise one read per step press.
//   Ports:
//     clk            in   1       system clock
//     reset          in   1       asynchronous active-low reset
//     w_button_run   in   1       raw run/pause button, active-low
//     w_button_step  in   1       raw step button, active-low
//     bus            master       read bus (rd_addr, rd_req, rd_data, rd_valid)
//     led            out  DATA_W  last successfully read byte
//     ss_lo / ss_hi  out  7       led nibbles, or "E" while err
//     ss_addr        out  7       address of the displayed byte
//     busy           out  1       read in progress (REQ or WAIT)
//     err            out  1       last read timed out
//
//   state | meaning
//   IDLE  | waiting for run or a step press
//   REQ   | rd_req pulse, timeout counter loaded
//   WAIT  | waiting for rd_valid or timeout
//   HOLD  | value on display; dwell in run mode, then advance address
module mem_scanner
  import mem_scanner_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DWELL   = DWELL_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_button_run,
  input  logic              w_button_step,
  mem_scanner_if.master     bus,
  output logic [DATA_W-1:0] led,
  output logic [6:0]        ss_lo,
  output logic [6:0]        ss_hi,
  output logic [6:0]        ss_addr,
  output logic              busy,
  output logic              err
);

  localparam int DW_W = $clog2(DWELL);
  localparam int TO_W = $clog2(TIMEOUT);
  localparam logic [DW_W-1:0] DW_LOAD = DW_W'(DWELL - 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_run;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_disp_addr;
  logic [DATA_W-1:0] r_led;
  logic              r_err;
  logic [TO_W-1:0]   r_to_cnt;
  logic [DW_W-1:0]   r_dw_cnt;
  logic              r_dw_tc;

  logic w_run_pls;
  logic w_step_pls;
  logic w_step_ok;
  logic w_cap;
  logic w_tmo;
  logic w_addr_inc;

  button_edge u_btn_run (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_btn_n (w_button_run),
    .o_pulse (w_run_pls)
  );

  button_edge u_btn_step (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_btn_n (w_button_step),
    .o_pulse (w_step_pls)
  );

  // A run press in the same cycle wins over step.
  assign w_step_ok = w_step_pls & ~w_run_pls & ~r_run & (r_state == ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_run_pls) begin
        r_run <= ~r_run;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_tmo       = 1'b0;
    w_addr_inc  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_run || w_step_ok) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.rd_valid) begin
          w_cap       = 1'b1;
          w_state_nxt = ST_HOLD;
        end else if (r_to_cnt == '0) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!r_run) begin
          w_addr_inc  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_dw_tc) begin
          w_addr_inc  = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Timeout and dwell are down-counters. The dwell terminal count is
  // registered, so HOLD lasts DWELL+1 clocks and the run-mode period is
  // DWELL + 2 + rd_valid latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= TO_LOAD;
      r_dw_cnt <= DW_LOAD;
      r_dw_tc  <= 1'b0;
    end else begin
      if (r_state == ST_REQ) begin
        r_to_cnt <= TO_LOAD;
      end else if (r_state == ST_WAIT && r_to_cnt != '0) begin
        r_to_cnt <= r_to_cnt - TO_W'(1);
      end

      if (r_state != ST_HOLD) begin
        r_dw_cnt <= DW_LOAD;
      end else if (r_dw_cnt != '0) begin
        r_dw_cnt <= r_dw_cnt - DW_W'(1);
      end

      r_dw_tc <= (r_state == ST_HOLD) && (w_state_nxt == ST_HOLD) && (r_dw_cnt == '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_addr   <= '0;
      r_disp_addr <= '0;
      r_led       <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_cap) begin
        r_led       <= bus.rd_data;
        r_disp_addr <= r_rd_addr;
        r_err       <= 1'b0;
      end else if (w_tmo) begin
        r_err <= 1'b1;
      end
      if (w_addr_inc) begin
        r_rd_addr <= r_rd_addr + ADDR_W'(1);
      end
    end
  end

  assign bus.rd_addr = r_rd_addr;
  assign bus.rd_req  = (r_state == ST_REQ);
  assign busy        = (r_state == ST_REQ) || (r_state == ST_WAIT);
  assign led         = r_led;
  assign err         = r_err;

  logic [3:0] w_hex_lo;
  logic [3:0] w_hex_hi;
  logic [3:0] w_hex_addr;

  assign w_hex_lo   = r_err ? 4'hE : r_led[3:0];
  assign w_hex_hi   = r_err ? 4'hE : r_led[7:4];
  assign w_hex_addr = 4'(r_disp_addr);

  hex2seven_seg u_seg_lo (
    .i_ce  (1'b1),
    .i_hex (w_hex_lo),
    .o_seg (ss_lo)
  );

  hex2seven_seg u_seg_hi (
    .i_ce  (1'b1),
    .i_hex (w_hex_hi),
    .o_seg (ss_hi)
  );

  hex2seven_seg u_seg_addr (
    .i_ce  (1'b1),
    .i_hex (w_hex_addr),
    .o_seg (ss_addr)
  );

endmodule

// File: tb/tb_mem_scanner.sv
// tb_mem_scanner
//   Directed bench for mem_scanner with a latency-configurable memory model.
module tb_mem_scanner;

  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 8;
  localparam int DWELL   = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_run_n = 1'b1;
  logic btn_step_n = 1'b1;
  logic [DATA_W-1:0] led;
  logic [6:0] ss_lo, ss_hi, ss_addr;
  logic busy, err;

  mem_scanner_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_scanner #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DWELL(DWELL), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (rst_n),
    .w_button_run  (btn_run_n),
    .w_button_step (btn_step_n),
    .bus           (bus),
    .led           (led),
    .ss_lo         (ss_lo),
    .ss_hi         (ss_hi),
    .ss_addr       (ss_addr),
    .busy          (busy),
    .err           (err)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int req_cnt = 0;

  // memory model controls; m_lat = 0 means never respond
  int          m_lat = 1;
  logic        ov_en = 1'b0;
  logic [2:0]  ov_addr = 3'd0;
  logic [7:0]  ov_data = 8'h00;

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (bus.rd_req === 1'b1) req_cnt++;
  end

  // rd_valid is asserted for one cycle, m_lat cycles after the rd_req cycle
  initial begin
    int         cnt;
    logic [2:0] addr;
    cnt = 0;
    addr = '0;
    bus.rd_valid = 1'b0;
    bus.rd_data  = 8'hEE;
    forever begin
      @(negedge clk);
      bus.rd_valid = 1'b0;
      bus.rd_data  = 8'hEE;
      if (bus.rd_req === 1'b1) begin
        if (m_lat != 0) begin
          cnt  = m_lat;
          addr = bus.rd_addr;
        end
      end else if (cnt != 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.rd_valid = 1'b1;
          bus.rd_data  = (ov_en && addr == ov_addr) ? ov_data : 8'(addr) * 8'h11;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  function automatic logic [6:0] seg7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
      4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
      4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
      4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
    endcase
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag, output int c, output logic [2:0] a);
    bit seen;
    seen = 1'b0;
    c = -1;
    a = '0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.rd_req === 1'b1) begin
        seen = 1'b1;
        c = cyc;
        a = bus.rd_addr;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic press(input bit r, input bit s, output int p);
    @(posedge clk);
    #2;
    if (r) btn_run_n = 1'b0;
    if (s) btn_step_n = 1'b0;
    p = cyc;
  endtask

  task automatic release_btns();
    btn_run_n = 1'b1;
    btn_step_n = 1'b1;
    step(4);
  endtask

  task automatic do_reset();
    btn_run_n = 1'b1;
    btn_step_n = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(4);
  endtask

  initial begin
    int p, p2, c, c2, prev, base;
    logic [2:0] a, a2;

    // 1: reset values
    step(3);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_addr", 32'(bus.rd_addr), 32'h0);
    chk("rst_req", 32'(bus.rd_req), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_ss_lo", 32'(ss_lo), 32'(seg7(4'h0)));
    chk("rst_ss_hi", 32'(ss_hi), 32'(seg7(4'h0)));
    chk("rst_ss_addr", 32'(ss_addr), 32'(seg7(4'h0)));
    @(negedge clk);
    rst_n = 1'b1;
    step(2);

    // 2: single step, latency 2, A5 at address 0
    m_lat = 2; ov_en = 1'b1; ov_addr = 3'd0; ov_data = 8'hA5;
    base = req_cnt;
    press(1'b0, 1'b1, p);
    wait_req("t2_req", c, a);
    chk("t2_req_addr", 32'(a), 32'd0);
    chk("t2_press_lat", 32'(c - p), 32'd4);
    step(2);
    chk("t2_led_early", 32'(led), 32'h00);
    chk("t2_busy_wait", 32'(busy), 32'd1);
    step(1);
    chk("t2_led", 32'(led), 32'hA5);
    chk("t2_addr_hold", 32'(bus.rd_addr), 32'd0);
    chk("t2_ss_lo", 32'(ss_lo), 32'(seg7(4'h5)));
    chk("t2_ss_hi", 32'(ss_hi), 32'(seg7(4'hA)));
    chk("t2_ss_addr", 32'(ss_addr), 32'(seg7(4'h0)));
    step(1);
    chk("t2_addr_next", 32'(bus.rd_addr), 32'd1);
    chk("t2_busy_idle", 32'(busy), 32'd0);
    release_btns();
    step(6);
    chk("t2_req_count", 32'(req_cnt - base), 32'd1);

    // 3: run mode, latency 1, full wrap
    do_reset();
    m_lat = 1; ov_en = 1'b0;
    press(1'b1, 1'b0, p);
    prev = 0;
    for (int i = 0; i < 9; i++) begin
      wait_req($sformatf("t3_req%0d", i), c, a);
      chk($sformatf("t3_addr%0d", i), 32'(a), 32'(i % 8));
      if (i == 0) chk("t3_first_lat", 32'(c - p), 32'd5);
      else chk($sformatf("t3_period%0d", i), 32'(c - prev), 32'd7);
      prev = c;
      step(2);
      chk($sformatf("t3_led%0d", i), 32'(led), 32'((i % 8) * 8'h11));
      chk($sformatf("t3_ss_addr%0d", i), 32'(ss_addr), 32'(seg7(4'(i % 8))));
    end
    release_btns();

    // 4: timeout, then recovery
    do_reset();
    m_lat = 1; ov_en = 1'b1; ov_addr = 3'd0; ov_data = 8'h3C;
    press(1'b0, 1'b1, p);
    wait_req("t4_pre", c, a);
    btn_step_n = 1'b1;
    step(4);
    chk("t4_pre_led", 32'(led), 32'h3C);
    chk("t4_pre_addr", 32'(bus.rd_addr), 32'd1);
    m_lat = 0;
    press(1'b0, 1'b1, p);
    wait_req("t4_req", c, a);
    btn_step_n = 1'b1;
    chk("t4_req_addr", 32'(a), 32'd1);
    step(16);
    chk("t4_err_early", 32'(err), 32'd0);
    chk("t4_busy_wait", 32'(busy), 32'd1);
    step(1);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_busy_hold", 32'(busy), 32'd0);
    chk("t4_led_kept", 32'(led), 32'h3C);
    chk("t4_ss_lo_E", 32'(ss_lo), 32'(seg7(4'hE)));
    chk("t4_ss_hi_E", 32'(ss_hi), 32'(seg7(4'hE)));
    chk("t4_ss_addr", 32'(ss_addr), 32'(seg7(4'h0)));
    step(1);
    chk("t4_addr_next", 32'(bus.rd_addr), 32'd2);
    m_lat = 1; ov_en = 1'b0;
    step(3);
    press(1'b0, 1'b1, p);
    wait_req("t4_good", c, a);
    btn_step_n = 1'b1;
    chk("t4_good_addr", 32'(a), 32'd2);
    step(2);
    chk("t4_err_clr", 32'(err), 32'd0);
    chk("t4_good_led", 32'(led), 32'h22);
    chk("t4_good_ss_lo", 32'(ss_lo), 32'(seg7(4'h2)));
    chk("t4_good_ss_addr", 32'(ss_addr), 32'(seg7(4'h2)));

    // 5: async reset in REQ and in WAIT, stale rd_valid afterwards
    do_reset();
    m_lat = 6; ov_en = 1'b1; ov_addr = 3'd0; ov_data = 8'h5A;
    press(1'b0, 1'b1, p);
    wait_req("t5a_req", c, a);
    btn_step_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("t5a_req_drop", 32'(bus.rd_req), 32'd0);
    chk("t5a_busy_drop", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(10);
    chk("t5a_led", 32'(led), 32'h00);
    press(1'b0, 1'b1, p);
    wait_req("t5b_req", c, a);
    btn_step_n = 1'b1;
    step(2);
    chk("t5b_busy_wait", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5b_busy_drop", 32'(busy), 32'd0);
    chk("t5b_req_low", 32'(bus.rd_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(10);
    chk("t5b_led_stale", 32'(led), 32'h00);
    chk("t5b_err", 32'(err), 32'd0);
    chk("t5b_addr", 32'(bus.rd_addr), 32'd0);
    chk("t5b_busy", 32'(busy), 32'd0);

    // 6: run+step together, then pause mid-dwell
    do_reset();
    m_lat = 1; ov_en = 1'b0;
    base = req_cnt;
    press(1'b1, 1'b1, p);
    wait_req("t6_req0", c, a);
    btn_run_n = 1'b1;
    btn_step_n = 1'b1;
    chk("t6_addr0", 32'(a), 32'd0);
    chk("t6_first_lat", 32'(c - p), 32'd5);
    wait_req("t6_req1", c2, a2);
    chk("t6_addr1", 32'(a2), 32'd1);
    chk("t6_period", 32'(c2 - c), 32'd7);
    press(1'b1, 1'b0, p2);
    step(12);
    chk("t6_pause_addr", 32'(bus.rd_addr), 32'd2);
    chk("t6_pause_busy", 32'(busy), 32'd0);
    chk("t6_req_count", 32'(req_cnt - base), 32'd2);
    chk("t6_led", 32'(led), 32'h11);
    chk("t6_ss_addr", 32'(ss_addr), 32'(seg7(4'h1)));
    release_btns();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
